instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 tb/tb_instr_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, a small instruction FIFO,
// and redirect handling that discards the response of a request made before the redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     instr_mem [QDEPTH];
  logic [31:0]     pc_mem    [QDEPTH];

  logic [31:0]     req_addr;
  logic [CW-1:0]   inflight;
  logic            can_issue, grant, push, pop;
  logic            unused_bits;

  assign req_addr    = {fetch_pc_q[31:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];

  // Requests are only issued when the returning word is guaranteed a free slot.
  always_comb begin
    inflight  = (state_q == S_WAIT) ? CW'(1) : '0;
    can_issue = (state_q == S_IDLE) || ((state_q == S_WAIT) && mem_rvalid);
    mem_req   = !rst && !redirect_valid && can_issue && ((count_q + inflight) < DEPTH_C);
    mem_addr  = rst ? '0 : req_addr;
    grant     = mem_req && mem_gnt;
    if_valid  = (count_q != '0);
    push      = !redirect_valid && (state_q == S_WAIT) && mem_rvalid;
    pop       = !redirect_valid && if_valid && if_ready;
    if_instr  = if_valid ? instr_mem[rptr_q] : '0;
    if_pc     = if_valid ? pc_mem[rptr_q]    : '0;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      // A response landing in the redirect cycle retires the outstanding request.
      state_d    = ((state_q != S_IDLE) && !mem_rvalid) ? S_DISCARD : S_IDLE;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        S_IDLE:    if (grant) state_d = S_WAIT;
        S_WAIT:    if (mem_rvalid) state_d = grant ? S_WAIT : S_IDLE;
        S_DISCARD: if (mem_rvalid) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)  wptr_d = wptr_q + AW'(1);
      if (pop)   rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage and the address of the outstanding request carry no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wptr_q] <= mem_rdata;
      pc_mem[wptr_q]    <= req_pc_q;
    end
    if (grant) req_pc_q <= req_addr;
  end

  assert property (@(posedge clk) disable iff (rst) !(push && !pop && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic checked
// every cycle against a queue-based reference model and a randomized-latency memory.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} ent_t;

  int          checks = 0;
  int          failures = 0;
  ent_t        mq[$];
  logic [31:0] m_pc = RESET_PC;
  bit          o_live = 0, o_stale = 0;
  logic [31:0] o_pc = '0;
  bit          pend_v = 0;
  int          pend_lat = 0;
  logic [31:0] pend_addr = '0;
  int          lat_min = 0, lat_max = 0;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance model and memory.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit gnt, input bit rdy);
    logic        rv;
    logic [31:0] rd, e_addr;
    bit          e_req, grant;
    @(negedge clk);
    rv = pend_v && (pend_lat == 0);
    rd = rv ? mdata(pend_addr) : $urandom();
    redirect_valid = redir; redirect_pc = rpc; mem_gnt = gnt;
    if_ready = rdy; mem_rvalid = rv; mem_rdata = rd;
    #1;
    e_addr = {m_pc[31:2], 2'b00};
    e_req  = !redir && ((!o_live && !o_stale) || (o_live && rv)) &&
             ((mq.size() + (o_live ? 1 : 0)) < QDEPTH);
    chk("mem_req", mem_req, e_req);
    if (e_req) chk("mem_addr", mem_addr, e_addr);
    chk("if_valid", if_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("if_instr", if_instr, mq[0].instr);
      chk("if_pc", if_pc, mq[0].pc);
    end
    s_req = mem_req; s_addr = mem_addr; s_valid = if_valid; s_pc = if_pc;
    grant = e_req && gnt;
    if (redir) begin
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (o_live && !rv) begin o_live = 0; o_stale = 1; end
      else if (rv) begin o_live = 0; o_stale = 0; end
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (o_live && rv) mq.push_back('{rd, o_pc});
      if (rv) begin o_live = 0; o_stale = 0; end
      if (grant) begin o_live = 1; o_pc = e_addr; m_pc = m_pc + 32'd4; end
    end
    if (rv) pend_v = 0;
    else if (pend_v) pend_lat--;
    if (mem_req && gnt) begin
      pend_v = 1; pend_addr = mem_addr; pend_lat = $urandom_range(lat_max, lat_min);
    end
  endtask

  task automatic do_reset(input bit keep_pending);
    @(negedge clk);
    rst = 1; redirect_valid = 0; redirect_pc = '0; mem_gnt = 0;
    mem_rvalid = 0; mem_rdata = '0; if_ready = 0;
    #1;
    chk("rst_mem_req", mem_req, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_valid", if_valid, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    @(negedge clk); #1;
    chk("rst_mem_req_hold", mem_req, 32'd0);
    chk("rst_if_valid_hold", if_valid, 32'd0);
    mq.delete(); m_pc = RESET_PC; o_live = 0; o_stale = 0;
    if (keep_pending) pend_lat = 0;
    else pend_v = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("first_req", mem_req, 32'd1);
    chk("first_addr", mem_addr, {RESET_PC[31:2], 2'b00});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev_pc, a0;
    bit seen_req, got;

    // Streaming at one instruction per cycle.
    lat_min = 0; lat_max = 0;
    do_reset(0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, '0, 1, 1);
      chk("seq_addr", s_addr, RESET_PC + 32'(4 * k));
      if (k >= 2) begin
        chk("seq_valid", s_valid, 32'd1);
        chk("seq_pc", s_pc, RESET_PC + 32'(4 * (k - 2)));
      end
    end

    // Back-pressure: queue fills to QDEPTH, then drains in order and fetch resumes.
    for (int k = 0; k < 12; k++) cycle(0, '0, 1, 0);
    chk("fill_req_off", s_req, 32'd0);
    chk("fill_valid", s_valid, 32'd1);
    chk("fill_depth", mq.size(), 32'd4);
    prev_pc = '0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, '0, 0, 1);
      chk("drain_valid", s_valid, 32'd1);
      if (i > 0) chk("drain_order", s_pc, prev_pc + 32'd4);
      if (i == 0) chk("drain_full_noreq", s_req, 32'd0);
      if (i == 1) chk("resume_req", s_req, 32'd1);
      prev_pc = s_pc;
    end

    // Grant withheld for three cycles: request held stable, no address skip.
    cycle(0, '0, 0, 1);
    a0 = s_addr;
    chk("stall_req", s_req, 32'd1);
    for (int i = 0; i < 2; i++) begin
      cycle(0, '0, 0, 1);
      chk("stall_req_hold", s_req, 32'd1);
      chk("stall_addr_hold", s_addr, a0);
    end
    cycle(0, '0, 1, 1);
    chk("stall_grant_addr", s_addr, a0);
    cycle(0, '0, 1, 1);
    chk("stall_no_skip", s_addr, a0 + 32'd4);

    // Redirect while a request is outstanding: stale response dropped.
    do_reset(0);
    lat_min = 2; lat_max = 2;
    cycle(0, '0, 1, 1);
    cycle(1, 32'h0000_1002, 1, 1);
    chk("redir_req_off", s_req, 32'd0);
    seen_req = 0; got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      cycle(0, '0, 1, 1);
      if (!seen_req && s_req) begin
        seen_req = 1;
        chk("redir_addr", s_addr, 32'h0000_1000);
      end
      if (s_valid) begin
        got = 1;
        chk("redir_first_pc", s_pc, 32'h0000_1000);
      end
    end
    chk("redir_seen_req", seen_req, 32'd1);
    chk("redir_got_instr", got, 32'd1);

    // Reset during an outstanding request, late response after release.
    do_reset(0);
    lat_min = 3; lat_max = 3;
    cycle(0, '0, 1, 1);
    cycle(0, '0, 0, 1);
    do_reset(1);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);
    chk("late_rvalid_dropped", s_valid, 32'd0);
    lat_min = 0; lat_max = 0;
    cycle(0, '0, 1, 1);
    chk("restart_addr", s_addr, RESET_PC);
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      cycle(0, '0, 1, 1);
      if (s_valid) begin
        got = 1;
        chk("restart_pc", s_pc, RESET_PC);
      end
    end
    chk("restart_got_instr", got, 32'd1);

    // Randomized traffic.
    lat_min = 0; lat_max = 3;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(999) < 3) do_reset(0);
      else cycle($urandom_range(99) < 4, $urandom(),
                 $urandom_range(99) < 70, $urandom_range(99) < 70);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
